// File: rtl/ysyx_22041412_lsu.sv
// ysyx_22041412_lsu: MEM-stage load/store unit.
// Checks each pipeline request for alignment and legality, runs the
// en/wen/ready handshake with the data-memory responder, captures load data,
// stalls the pipeline until completion and aborts accesses the memory never
// answers.
module ysyx_22041412_lsu #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // pipeline side
    input  logic                  req_valid,
    input  logic                  req_wen,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  lsu_stall,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic                  timeout,
    // memory side
    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [2:0]            mem_func3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ready_i,
    input  logic                  mem_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] wd_cnt;
    logic        misaligned;
    logic        req_illegal;
    logic        wd_hit;
    logic        accept;

    // Request legality: natural alignment, no wide stores, no funct3=111
    // load, and no load from address 0 (the responder never answers it).
    always_comb begin
        unique case (req_func3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned = (req_addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
        req_illegal = misaligned
                    | (req_wen & req_func3[2])
                    | (~req_wen & (req_func3 == 3'b111))
                    | (~req_wen & (req_addr == '0));
    end

    // Watchdog fires on the last allowed BUSY cycle; TIMEOUT=0 disables it.
    assign wd_hit = (TIMEOUT != 0) && (wd_cnt == 32'(TIMEOUT - 1));

    // A stray ready_o in IDLE is drained first and blocks any new accept.
    assign accept = (state == S_IDLE) & ~mem_ready_o & req_valid & ~req_illegal;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and the state-decoded handshake/response outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        mem_ready_i = 1'b0;
        resp_valid  = 1'b0;
        resp_fault  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mem_ready_o)    mem_ready_i = 1'b1;
                else if (req_valid) state_nxt   = req_illegal ? S_ERR : S_BUSY;
            end
            S_BUSY: begin
                if (mem_ready_o) state_nxt = S_ACK;
                else if (wd_hit) state_nxt = S_ERR;
            end
            S_ACK: begin
                mem_ready_i = 1'b1;
                resp_valid  = 1'b1;
                state_nxt   = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_fault = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign lsu_stall = req_valid & ((state == S_IDLE) | (state == S_BUSY));

    // Memory request registers, watchdog counter, load data and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_wen    <= 1'b0;
            mem_func3  <= 3'b000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            timeout    <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            if (accept) begin
                mem_en    <= 1'b1;
                mem_wen   <= req_wen;
                mem_func3 <= req_func3;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                wd_cnt    <= '0;
            end
            if (state == S_BUSY) begin
                wd_cnt <= wd_cnt + 32'd1;
                // mem_en drops with the ready so the memory never reissues.
                if (mem_ready_o) begin
                    mem_en <= 1'b0;
                    if (!mem_wen) resp_rdata <= mem_rdata;
                end else if (wd_hit) begin
                    mem_en  <= 1'b0;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Self-checking bench for ysyx_22041412_lsu: a behavioural memory responder
// with programmable latency, plus a transaction-level reference that predicts
// response cycle, fault, data, mem_en duration and stall length per request.
module tb_ysyx_22041412_lsu;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_wen;
    logic [2:0]    req_func3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          lsu_stall, resp_valid, resp_fault, timeout;
    logic [DW-1:0] resp_rdata;
    logic          mem_en, mem_wen, mem_ready_i;
    logic [2:0]    mem_func3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready_o = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    ysyx_22041412_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wen(req_wen), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_stall(lsu_stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .timeout(timeout),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready_i(mem_ready_i), .mem_ready_o(mem_ready_o), .mem_rdata(mem_rdata)
    );

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- memory responder ----------------
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int         lat     = 1;
    bit         silent  = 1'b0;
    int         wait_cnt = 0;

    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] raw);
        case (f3)
            3'b000:  return {{56{raw[7]}},  raw[7:0]};
            3'b001:  return {{48{raw[15]}}, raw[15:0]};
            3'b010:  return {{32{raw[31]}}, raw[31:0]};
            3'b100:  return {56'b0, raw[7:0]};
            3'b101:  return {48'b0, raw[15:0]};
            3'b110:  return {32'b0, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [63:0] read_mem(input logic [63:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[8'(a[7:0] + 8'(i))];
        return r;
    endfunction

    function automatic logic [63:0] read_ref(input logic [63:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
        return r;
    endfunction

    // Answers `lat` cycles after it first sees en; drops ready_o on ready_i.
    always @(posedge clk) begin
        if (mem_ready_o && mem_ready_i) begin
            mem_ready_o <= 1'b0;
            wait_cnt    <= 0;
        end else if (mem_en && !mem_ready_o) begin
            if (!silent && mem_addr != 0 && wait_cnt + 1 >= lat) begin
                mem_ready_o <= 1'b1;
                wait_cnt    <= 0;
                if (mem_wen) begin
                    for (int i = 0; i < 8; i++)
                        if (i < (1 << mem_func3[1:0]))
                            mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
                end else begin
                    mem_rdata <= extend(mem_func3, read_mem(mem_addr));
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else if (!mem_en) begin
            wait_cnt <= 0;
        end
    end

    // ---------------- reference state ----------------
    logic [63:0] ref_rdata = '0;
    bit          ref_to    = 1'b0;

    function automatic bit is_legal(input bit wen, input logic [2:0] f3, input logic [63:0] a);
        int size;
        size = 1 << f3[1:0];
        if ((a % 64'(size)) != 0) return 0;
        if (wen && f3 > 3) return 0;
        if (!wen && f3 == 3'd7) return 0;
        if (!wen && a == 0) return 0;
        return 1;
    endfunction

    // Issues one request at the start of a cycle and follows it to its response.
    task automatic do_req(input bit wen, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int l, input string tag);
        int          exp_cyc, exp_en;
        bit          exp_fault;
        int          resp_cyc = -1;
        int          en_cnt = 0, stall_cnt = 0, unstable = 0;
        logic [63:0] got_rdata = '0;
        logic        got_fault = 1'b0, got_rdy = 1'b0, got_to = 1'b0;

        if (!is_legal(wen, f3, a)) begin
            exp_cyc = 1; exp_en = 0; exp_fault = 1;
        end else if (silent || l + 1 > TO) begin
            exp_cyc = TO + 1; exp_en = TO; exp_fault = 1; ref_to = 1;
        end else begin
            exp_cyc = l + 2; exp_en = l + 1; exp_fault = 0;
            if (wen) begin
                for (int i = 0; i < (1 << f3[1:0]); i++)
                    ref_mem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
            end else begin
                ref_rdata = extend(f3, read_ref(a));
            end
        end

        lat       = l;
        req_valid = 1'b1;
        req_wen   = wen;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                if ({mem_wen, mem_func3, mem_addr, mem_wdata} !== {wen, f3, a, wd}) unstable++;
            end
            if (lsu_stall) stall_cnt++;
            if (resp_valid) begin
                resp_cyc  = c;
                got_fault = resp_fault;
                got_rdata = resp_rdata;
                got_rdy   = mem_ready_i;
                got_to    = timeout;
            end
            @(posedge clk); #1;
            if (resp_cyc >= 0) break;
            // Requests are only sampled in IDLE; anything here must be ignored.
            req_wen   = 1'($urandom);
            req_func3 = 3'($urandom);
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
        end
        check({tag, " resp_cycle"}, 64'(resp_cyc), 64'(exp_cyc));
        check({tag, " fault"},      64'(got_fault), 64'(exp_fault));
        check({tag, " rdata"},      got_rdata, ref_rdata);
        check({tag, " en_cycles"},  64'(en_cnt), 64'(exp_en));
        check({tag, " stall"},      64'(stall_cnt), 64'(exp_cyc));
        check({tag, " mem_stable"}, 64'(unstable), 64'd0);
        check({tag, " ready_i"},    64'(got_rdy), 64'(!exp_fault));
        check({tag, " timeout"},    64'(got_to), 64'(ref_to));
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  f3;
        bit          w;

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 8; i++) begin
            mem[8 + i]     = 8'(8'h88 - 8'(i) * 8'h11);
            ref_mem[8 + i] = mem[8 + i];
        end
        mem[3] = 8'hFF; ref_mem[3] = 8'hFF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset outs", {mem_en, mem_wen, mem_func3, mem_ready_i, resp_valid,
                             resp_fault, timeout, lsu_stall}, 64'd0);
        check("reset mem_addr",   mem_addr, 64'd0);
        check("reset mem_wdata",  mem_wdata, 64'd0);
        check("reset resp_rdata", resp_rdata, 64'd0);
        @(posedge clk); #1;

        do_req(0, 3'b011, 64'h8000_0008, 64'd0, 1, "ld");
        check("ld value", ref_rdata, 64'h1122334455667788);
        do_req(1, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, 1, "sw");
        do_req(0, 3'b001, 64'h8000_0001, 64'd0, 1, "lh_misaligned");
        do_req(0, 3'b011, 64'h0, 64'd0, 1, "ld_addr0");
        idle_cycle();

        do_req(0, 3'b100, 64'h8000_0003, 64'd0, 1, "lbu");
        do_req(0, 3'b000, 64'h8000_0003, 64'd0, 1, "lb_b2b");
        idle_cycle();

        silent = 1'b1;
        do_req(0, 3'b011, 64'h8000_0020, 64'd0, 1, "watchdog");
        silent = 1'b0;
        idle_cycle();
        repeat (3) @(posedge clk);
        #1;
        check("timeout sticky", 64'(timeout), 64'd1);

        // Reset in BUSY while the memory raises ready_o in the same edge.
        lat = 1; req_valid = 1'b1; req_wen = 1'b0; req_func3 = 3'b011;
        req_addr = 64'h8000_0010; req_wdata = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ref_rdata = '0; ref_to = 1'b0;
        @(negedge clk);
        check("rst mem_en",      64'(mem_en), 64'd0);
        check("rst drain",       64'(mem_ready_i & mem_ready_o), 64'd1);
        check("rst no resp",     64'(resp_valid), 64'd0);
        check("rst timeout clr", 64'(timeout), 64'd0);
        @(posedge clk); #1;
        do_req(0, 3'b011, 64'h8000_0010, 64'd0, 2, "after_rst");

        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom);
            a  = 64'h8000_0000 + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << f3[1:0]) - 1);
            if (!w && $urandom_range(0, 9) == 0) a = 64'h0;
            do_req(w, f3, a, {$urandom, $urandom}, $urandom_range(1, 3), "rand");
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
